c2h_frame_tx: RTL and testbench

- C2H stream source in the user application; the transmit counterpart of the H2C stream sink.
- Builds one frame of deterministic counter data per start command and drives it onto the XDMA C2H AXI4-Stream slave port.
- After the last beat it optionally raises a user interrupt and holds it until the XDMA acknowledges.
- Used for host-side DMA throughput and data-integrity tests.

---
 rtl/dma_app_pkg.sv | 35 +++
 rtl/c2h_pattern_gen.sv | 44 ++++
 rtl/c2h_frame_tx.sv | 158 +++++++++++++++
 tb/tb_c2h_frame_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_app_pkg.sv
// Shared types and helpers for the DMA test-application stream blocks.
// Beat count and byte-enable mask are computed here so sources and sinks agree.
package dma_app_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      IRQ_WAIT = 2'd2
   } state_t;

   localparam int WORD_W     = 32;
   localparam int MAX_KEEP_W = 64;

   // Number of stream beats needed to carry len bytes.
   function automatic logic [31:0] beats_of(input logic [31:0] len,
                                            input int unsigned bytes_per_beat);
      logic [31:0] bpb;
      bpb = 32'(bytes_per_beat);
      return (len + bpb - 32'd1) / bpb;
   endfunction

   // Byte enables for the final beat; rem == 0 means a completely full beat.
   function automatic logic [MAX_KEEP_W-1:0] keep_mask(input logic [31:0] rem,
                                                       input int unsigned bytes_per_beat);
      logic [MAX_KEEP_W-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
         if ((i < bytes_per_beat) && ((rem == 32'd0) || (i < rem))) begin
            mask[i] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/c2h_pattern_gen.sv
// Counter-pattern beat generator: word j of the presented beat is base + j.
// load seeds the first beat, advance steps to the next beat after a handshake.
module c2h_pattern_gen
   import dma_app_pkg::*;
#(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [31:0]           seed,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int W = DATA_WIDTH / WORD_W;

   logic [31:0]           base_reg;
   logic [31:0]           src;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [DATA_WIDTH-1:0] data_next;

   // base_reg always holds the first word of the beat after the one on the bus.
   assign src = load ? seed : base_reg;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_word
         assign data_next[gi*WORD_W +: WORD_W] = src + 32'(gi);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_reg <= '0;
         data_reg <= '0;
      end else if (load || advance) begin
         data_reg <= data_next;
         base_reg <= src + 32'(W);
      end
   end

   assign data = data_reg;

endmodule

// File: rtl/c2h_frame_tx.sv
// C2H stream source: one counter-pattern frame per start command onto the
// XDMA C2H AXI4-Stream port, with an optional interrupt handshake at frame end.
module c2h_frame_tx
   import dma_app_pkg::*;
#(
   parameter int DATA_WIDTH      = 128,
   parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
   parameter int IRQ_WIDTH       = 1,
   parameter int LEN_WIDTH       = 16
) (
   input  logic                       user_clk,
   input  logic                       user_aresetn,
   input  logic                       cfg_start,
   input  logic [LEN_WIDTH-1:0]       cfg_len,
   input  logic [31:0]                cfg_seed,
   input  logic                       cfg_irq_en,
   output logic [DATA_WIDTH-1:0]      m_axis_c2h_tdata,
   output logic [BYTE_BIT_ENABLE-1:0] m_axis_c2h_tkeep,
   output logic                       m_axis_c2h_tlast,
   output logic                       m_axis_c2h_tvalid,
   input  logic                       m_axis_c2h_tready,
   output logic [IRQ_WIDTH-1:0]       irq_req,
   input  logic [IRQ_WIDTH-1:0]       irq_ack,
   output logic                       busy,
   output logic                       done,
   output logic                       err_len,
   output logic [31:0]                frame_cnt
);

   state_t                     state_reg;
   logic [LEN_WIDTH-1:0]       beat_reg;
   logic [LEN_WIDTH-1:0]       last_idx_reg;
   logic [BYTE_BIT_ENABLE-1:0] last_keep_reg;
   logic [BYTE_BIT_ENABLE-1:0] tkeep_reg;
   logic                       irq_en_reg;
   logic                       tvalid_reg;
   logic                       tlast_reg;
   logic                       irq_reg;
   logic                       done_reg;
   logic                       err_reg;
   logic [31:0]                frame_cnt_reg;

   logic                       start_ok;
   logic                       advance;
   logic [LEN_WIDTH-1:0]       start_nb;
   logic [LEN_WIDTH-1:0]       start_rem;
   logic [BYTE_BIT_ENABLE-1:0] start_last_keep;
   logic [LEN_WIDTH-1:0]       next_beat;
   logic                       unused_ack;

   assign start_ok  = cfg_start && (state_reg == IDLE) && (cfg_len != '0);
   assign advance   = (state_reg == SEND) && m_axis_c2h_tready && !tlast_reg;
   assign next_beat = beat_reg + LEN_WIDTH'(1);

   // Only bit 0 of the acknowledge takes part in the handshake.
   assign unused_ack = ^irq_ack;

   always_comb begin
      start_nb        = LEN_WIDTH'(beats_of(32'(cfg_len), BYTE_BIT_ENABLE));
      start_rem       = LEN_WIDTH'(32'(cfg_len) % 32'(BYTE_BIT_ENABLE));
      start_last_keep = BYTE_BIT_ENABLE'(keep_mask(32'(start_rem), BYTE_BIT_ENABLE));
   end

   c2h_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pattern_gen (
      .clk     (user_clk),
      .rst_n   (user_aresetn),
      .load    (start_ok),
      .seed    (cfg_seed),
      .advance (advance),
      .data    (m_axis_c2h_tdata)
   );

   always_ff @(posedge user_clk or negedge user_aresetn) begin
      if (!user_aresetn) begin
         state_reg     <= IDLE;
         beat_reg      <= '0;
         last_idx_reg  <= '0;
         last_keep_reg <= '0;
         tkeep_reg     <= '0;
         irq_en_reg    <= 1'b0;
         tvalid_reg    <= 1'b0;
         tlast_reg     <= 1'b0;
         irq_reg       <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cfg_start) begin
                  if (cfg_len == '0) begin
                     err_reg <= 1'b1;
                  end else begin
                     beat_reg      <= '0;
                     last_idx_reg  <= start_nb - LEN_WIDTH'(1);
                     last_keep_reg <= start_last_keep;
                     irq_en_reg    <= cfg_irq_en;
                     tvalid_reg    <= 1'b1;
                     tlast_reg     <= (start_nb == LEN_WIDTH'(1));
                     tkeep_reg     <= (start_nb == LEN_WIDTH'(1)) ? start_last_keep : '1;
                     state_reg     <= SEND;
                  end
               end
            end
            SEND: begin
               // tvalid is held high for the whole of SEND, so tready alone marks a handshake.
               if (m_axis_c2h_tready) begin
                  if (tlast_reg) begin
                     tvalid_reg    <= 1'b0;
                     tlast_reg     <= 1'b0;
                     tkeep_reg     <= '0;
                     frame_cnt_reg <= frame_cnt_reg + 32'd1;
                     if (irq_en_reg) begin
                        irq_reg   <= 1'b1;
                        state_reg <= IRQ_WAIT;
                     end else begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                     end
                  end else begin
                     beat_reg  <= next_beat;
                     tlast_reg <= (next_beat == last_idx_reg);
                     tkeep_reg <= (next_beat == last_idx_reg) ? last_keep_reg : '1;
                  end
               end
            end
            IRQ_WAIT: begin
               if (irq_ack[0]) begin
                  irq_reg   <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      irq_req    = '0;
      irq_req[0] = irq_reg;
   end

   assign m_axis_c2h_tkeep  = tkeep_reg;
   assign m_axis_c2h_tlast  = tlast_reg;
   assign m_axis_c2h_tvalid = tvalid_reg;
   assign busy              = (state_reg != IDLE);
   assign done              = done_reg;
   assign err_len           = err_reg;
   assign frame_cnt         = frame_cnt_reg;

endmodule

// File: tb/tb_c2h_frame_tx.sv
// Scoreboard bench for c2h_frame_tx: stimulus queues expected beats, a
// negedge monitor pops and compares every handshake and checks stall stability.
module tb_c2h_frame_tx;

   localparam int DW = 128;
   localparam int KW = DW / 8;
   localparam int IW = 1;
   localparam int LW = 16;

   logic          user_clk;
   logic          user_aresetn;
   logic          cfg_start;
   logic [LW-1:0] cfg_len;
   logic [31:0]   cfg_seed;
   logic          cfg_irq_en;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tlast;
   logic          tvalid;
   logic          tready;
   logic [IW-1:0] irq_req;
   logic [IW-1:0] irq_ack;
   logic          busy;
   logic          done;
   logic          err_len;
   logic [31:0]   frame_cnt;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks   = 0;
   int    n_pass     = 0;
   int    beats_seen = 0;

   c2h_frame_tx #(
      .DATA_WIDTH      (DW),
      .BYTE_BIT_ENABLE (KW),
      .IRQ_WIDTH       (IW),
      .LEN_WIDTH       (LW)
   ) dut (
      .user_clk          (user_clk),
      .user_aresetn      (user_aresetn),
      .cfg_start         (cfg_start),
      .cfg_len           (cfg_len),
      .cfg_seed          (cfg_seed),
      .cfg_irq_en        (cfg_irq_en),
      .m_axis_c2h_tdata  (tdata),
      .m_axis_c2h_tkeep  (tkeep),
      .m_axis_c2h_tlast  (tlast),
      .m_axis_c2h_tvalid (tvalid),
      .m_axis_c2h_tready (tready),
      .irq_req           (irq_req),
      .irq_ack           (irq_ack),
      .busy              (busy),
      .done              (done),
      .err_len           (err_len),
      .frame_cnt         (frame_cnt)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Expected beat k of a frame: word j = seed + 4k + j, short keep on a partial last beat.
   function automatic beat_t model_beat(input logic [31:0] seed, input int len, input int k);
      beat_t b;
      int nb;
      int r;
      nb = (len + KW - 1) / KW;
      r  = len % KW;
      for (int j = 0; j < DW / 32; j++) b.data[32*j +: 32] = seed + 32'(k * (DW / 32) + j);
      b.last = (k == nb - 1);
      b.keep = '1;
      if (b.last && r != 0) b.keep = KW'((1 << r) - 1);
      return b;
   endfunction

   task automatic push_beats(input logic [31:0] seed, input int len, input int count);
      for (int k = 0; k < count; k++) exp_q.push_back(model_beat(seed, len, k));
   endtask

   task automatic start(input int len, input logic [31:0] seed, input logic irq_en);
      @(posedge user_clk);
      #1;
      cfg_start  = 1'b1;
      cfg_len    = LW'(len);
      cfg_seed   = seed;
      cfg_irq_en = irq_en;
      @(posedge user_clk);
      #1;
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      logic got;
      got = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge user_clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      chk(name, got, 1'b1);
   endtask

   // Monitor: one line per accepted beat, plus hold checks while stalled.
   initial begin
      logic          stall;
      logic [DW-1:0] pd;
      logic [KW-1:0] pk;
      logic          pl;
      beat_t         e;
      stall = 1'b0;
      pd    = '0;
      pk    = '0;
      pl    = 1'b0;
      forever begin
         @(negedge user_clk);
         if (!user_aresetn) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_valid", tvalid, 1'b1);
               chk("hold_data", tdata, pd);
               chk("hold_keep", tkeep, pk);
               chk("hold_last", tlast, pl);
            end
            if (tvalid && tready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_beat: got %h, expected no beat", tdata);
               end else begin
                  e = exp_q.pop_front();
                  $display("beat %0d: data=%h keep=%h last=%0d", beats_seen, tdata, tkeep, tlast);
                  chk("beat_data", tdata, e.data);
                  chk("beat_keep", tkeep, e.keep);
                  chk("beat_last", tlast, e.last);
               end
               beats_seen++;
            end
            stall = tvalid && !tready;
            pd    = tdata;
            pk    = tkeep;
            pl    = tlast;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pat[6];
      int seen0;
      pat = '{1, 0, 0, 1, 0, 1};
      user_aresetn = 1'b0;
      cfg_start    = 1'b0;
      cfg_len      = '0;
      cfg_seed     = '0;
      cfg_irq_en   = 1'b0;
      tready       = 1'b1;
      irq_ack      = '0;

      // Reset state
      @(negedge user_clk);
      chk("rst_tvalid", tvalid, 1'b0);
      chk("rst_tdata", tdata, '0);
      chk("rst_tkeep", tkeep, '0);
      chk("rst_tlast", tlast, 1'b0);
      chk("rst_irq", irq_req, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_flags", {done, err_len}, 2'b00);
      chk("rst_frame_cnt", frame_cnt, 32'd0);
      @(posedge user_clk);
      #1;
      user_aresetn = 1'b1;

      // Frame 1: len 64, seed 0, irq on
      exp_q.push_back('{data: 128'h00000003_00000002_00000001_00000000, keep: 16'hFFFF, last: 1'b0});
      exp_q.push_back('{data: 128'h00000007_00000006_00000005_00000004, keep: 16'hFFFF, last: 1'b0});
      exp_q.push_back('{data: 128'h0000000B_0000000A_00000009_00000008, keep: 16'hFFFF, last: 1'b0});
      exp_q.push_back('{data: 128'h0000000F_0000000E_0000000D_0000000C, keep: 16'hFFFF, last: 1'b1});
      start(64, 32'd0, 1'b1);
      @(negedge user_clk);
      chk("f1_latency_tvalid", tvalid, 1'b1);
      chk("f1_busy", busy, 1'b1);
      repeat (4) @(posedge user_clk);
      @(negedge user_clk);
      chk("f1_irq_req", irq_req, 1'b1);
      chk("f1_tvalid_off", tvalid, 1'b0);
      chk("f1_frame_cnt", frame_cnt, 32'd1);
      repeat (3) @(posedge user_clk);
      #1;
      irq_ack = 1'b1;
      @(negedge user_clk);
      chk("f1_irq_held", irq_req, 1'b1);
      chk("f1_no_early_done", done, 1'b0);
      @(posedge user_clk);
      #1;
      irq_ack = 1'b0;
      @(negedge user_clk);
      chk("f1_done", done, 1'b1);
      chk("f1_irq_cleared", irq_req, 1'b0);
      chk("f1_idle", busy, 1'b0);

      // Frame 2: len 20, seed wraps through 2^32
      exp_q.push_back('{data: 128'h00000001_00000000_FFFFFFFF_FFFFFFFE, keep: 16'hFFFF, last: 1'b0});
      exp_q.push_back('{data: 128'h00000005_00000004_00000003_00000002, keep: 16'h000F, last: 1'b1});
      start(20, 32'hFFFF_FFFE, 1'b0);
      @(negedge user_clk);
      chk("f2_latency_tvalid", tvalid, 1'b1);
      repeat (2) @(posedge user_clk);
      @(negedge user_clk);
      chk("f2_done", done, 1'b1);
      chk("f2_no_irq", irq_req, 1'b0);
      chk("f2_frame_cnt", frame_cnt, 32'd2);

      // Frame 3: len 48 with tready toggling
      push_beats(32'h9E37_79B9, 48, 3);
      seen0 = beats_seen;
      start(48, 32'h9E37_79B9, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tready = (pat[i] != 0);
         @(posedge user_clk);
         #1;
      end
      tready = 1'b1;
      @(negedge user_clk);
      chk("f3_done", done, 1'b1);
      chk("f3_beat_count", beats_seen - seen0, 3);
      chk("f3_frame_cnt", frame_cnt, 32'd3);

      // Zero length is rejected
      start(0, 32'h1111_1111, 1'b1);
      @(negedge user_clk);
      chk("zl_err_len", err_len, 1'b1);
      chk("zl_tvalid", tvalid, 1'b0);
      chk("zl_busy", busy, 1'b0);
      @(negedge user_clk);
      chk("zl_err_once", err_len, 1'b0);
      chk("zl_still_idle", {busy, tvalid}, 2'b00);

      // Starts during SEND and IRQ_WAIT are ignored, then back-to-back frames
      push_beats(32'd100, 64, 4);
      start(64, 32'd100, 1'b1);
      cfg_start  = 1'b1;
      cfg_len    = LW'(16);
      cfg_seed   = 32'hDEAD_BEEF;
      cfg_irq_en = 1'b0;
      @(posedge user_clk);
      #1;
      cfg_start = 1'b0;
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      chk("ig_irq_req", irq_req, 1'b1);
      cfg_start = 1'b1;
      @(posedge user_clk);
      #1;
      cfg_start = 1'b0;
      irq_ack   = 1'b1;
      @(posedge user_clk);
      #1;
      irq_ack    = 1'b0;
      cfg_start  = 1'b1;
      cfg_len    = LW'(16);
      cfg_seed   = 32'h0000_1000;
      cfg_irq_en = 1'b0;
      push_beats(32'h0000_1000, 16, 1);
      @(negedge user_clk);
      chk("ig_done", done, 1'b1);
      chk("ig_frame_cnt", frame_cnt, 32'd4);
      chk("ig_tvalid", tvalid, 1'b0);
      @(posedge user_clk);
      #1;
      cfg_start = 1'b0;
      @(negedge user_clk);
      chk("b2b_a_latency", tvalid, 1'b1);
      @(posedge user_clk);
      #1;
      cfg_start = 1'b1;
      cfg_len   = LW'(32);
      cfg_seed  = 32'h0000_2000;
      push_beats(32'h0000_2000, 32, 2);
      @(negedge user_clk);
      chk("b2b_a_done", done, 1'b1);
      @(posedge user_clk);
      #1;
      cfg_start = 1'b0;
      @(negedge user_clk);
      chk("b2b_b_latency", tvalid, 1'b1);
      wait_done("b2b_b_done", 10);
      chk("b2b_frame_cnt", frame_cnt, 32'd6);

      // Reset during beat 2 of 8
      push_beats(32'hA5A5_0000, 128, 2);
      start(128, 32'hA5A5_0000, 1'b0);
      @(posedge user_clk);
      @(posedge user_clk);
      #2;
      user_aresetn = 1'b0;
      #1;
      chk("ar_tvalid", tvalid, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_frame_cnt", frame_cnt, 32'd0);
      chk("ar_irq", irq_req, '0);
      chk("ar_queue_drained", exp_q.size(), 0);
      repeat (2) @(posedge user_clk);
      #1;
      user_aresetn = 1'b1;
      @(negedge user_clk);
      chk("ar_no_resume", {busy, tvalid}, 2'b00);
      push_beats(32'hA5A5_0000, 32, 2);
      start(32, 32'hA5A5_0000, 1'b0);
      wait_done("ar_new_done", 10);
      chk("ar_new_frame_cnt", frame_cnt, 32'd1);

      repeat (2) @(negedge user_clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
